bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared system bus. Grants ownership to one of NUM_MASTERS bus masters; the CPU instruction-fetch and memory-stage bus interfaces are two of them.
- Masters use the active-low request/grant pair: drive req_ low, wait for grnt_ low, run the access, then release req_.
- Grants are never preempted.
- A hold-time watchdog flags a master that keeps the bus too long.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- IDX_W, 2, width of owner index; must equal ceil(log2(NUM_MASTERS)).
- TIMEOUT, 255, grant-hold cycles before timeout_err sets; 0 disables the watchdog.
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W-1 >= TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- m_req_  in  NUM_MASTERS  per-master bus request, active low.
- m_grnt_  out  NUM_MASTERS  per-master bus grant, active low, registered, at most one bit low.
- owner  out  IDX_W  index of current grant holder; valid only when owner_vld=1.
- owner_vld  out  1  high while some master holds a grant.
- timeout_err  out  1  sticky watchdog flag.
- err_clr  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset (async, active-high), effective immediately regardless of state:
  - m_grnt_ = all 1, owner = 0, owner_vld = 0, timeout_err = 0.
  - Internal priority pointer ptr = 0, hold counter cnt = 0, state = IDLE.
- Priority search: scan indices ptr, ptr+1, ... modulo NUM_MASTERS; select the first index with m_req_ low.
- IDLE state:
  - No request pending: stay IDLE, outputs unchanged.
  - Any m_req_ bit low at edge N: at edge N the selected grant drives low, owner=sel, owner_vld=1, cnt=0, state -> GRANT.
  - Latency from request sample to grant output: 1 cycle.
- GRANT state, owner still requesting (m_req_[owner]=0):
  - Hold grant; all other requests ignored (no preemption).
  - cnt increments, saturating at all-ones.
- GRANT state, owner releases (m_req_[owner]=1 sampled):
  - m_grnt_[owner] -> 1.
  - ptr <= (owner+1) mod NUM_MASTERS; wrap from NUM_MASTERS-1 to 0.
  - Another request pending: search starting from (owner+1) mod NUM_MASTERS. On the same edge the new grant goes low, owner updates, cnt=0, state stays GRANT. Handover has no idle cycle; the old and new grants never overlap.
  - No request pending: owner_vld=0, owner keeps its old value, state -> IDLE.
- A released owner that re-requests is arbitrated normally. Because ptr has advanced, it has lowest priority.
- Watchdog:
  - When TIMEOUT!=0 and cnt==TIMEOUT-1 while the grant is held, timeout_err sets on the next edge. The flag therefore sets after TIMEOUT consecutive held cycles.
  - Grant is not revoked.
  - err_clr=1 clears timeout_err. If set and clear happen on the same edge, set wins.
  - TIMEOUT=0: timeout_err stays 0.
- Requests whose bit is high are never granted.
- m_grnt_ is always one-hot-low or all-high.

Test Plan:
- Reset: assert reset mid-GRANT with master 2 owning. Required: m_grnt_=4'b1111, owner_vld=0, timeout_err=0 immediately. After release, a request from master 3 alone is granted 1 cycle later.
- Single request: with the arbiter idle, drive m_req_=4'b1110 at cycle 0. Required: m_grnt_=4'b1110, owner=0, owner_vld=1 after the cycle-1 edge. Release at cycle 5: m_grnt_=4'b1111 and owner_vld=0 after the next edge.
- Round-robin: hold m_req_=4'b0000 continuously, with each owner releasing for one cycle after 3 cycles of grant. Required: grant sequence 0,1,2,3,0 with back-to-back handover and no cycle with two grants low.
- Pointer wrap and priority: master 3 owns and releases while masters 1 and 0 request. Required: master 0 is granted next, then master 1.
- Watchdog: TIMEOUT=4, master 1 holds the grant for 10 cycles. Required: timeout_err rises after the 4th held cycle, grant stays 4'b1101, and err_clr=1 for one cycle clears the flag.
- Set/clear collision: err_clr=1 on the same edge the watchdog fires. Required: timeout_err=1.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Request/grant bus shared between the round-robin arbiter and its masters.
// Requests and grants are active low; owner is meaningful only while owner_vld is high.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2
);
  logic [NUM_MASTERS-1:0] m_req_;
  logic [NUM_MASTERS-1:0] m_grnt_;
  logic [IDX_W-1:0]       owner;
  logic                   owner_vld;
  logic                   timeout_err;
  logic                   err_clr;

  modport master (
    output m_req_, err_clr,
    input  m_grnt_, owner, owner_vld, timeout_err
  );

  modport slave (
    input  m_req_, err_clr,
    output m_grnt_, owner, owner_vld, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Non-preemptive round-robin bus arbiter with registered active-low grants
// and a sticky hold-time watchdog.
//
// state | meaning
// IDLE  | no master owns the bus, grants all high
// GRANT | owner holds the bus until it releases its request
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit               WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_MASTERS - 1);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic                   vld_q, vld_d;
  logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic                   any_req;
  logic [IDX_W-1:0]       nxt_idx;
  logic [IDX_W-1:0]       sel;

  // First low request scanning upward from start, wrapping at NUM_MASTERS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req_n,
                                               input logic [IDX_W-1:0]       start);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = start;
    found   = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = IDX_W'((int'(start) + i) % NUM_MASTERS);
      if (!found && !req_n[idx]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

  assign any_req = ~&bus.m_req_;
  assign nxt_idx = (owner_q == IDX_MAX) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      vld_q   <= 1'b0;
      grnt_q  <= '1;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      vld_q   <= vld_d;
      grnt_q  <= grnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    vld_d   = vld_q;
    grnt_d  = grnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sel     = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel     = rr_pick(bus.m_req_, ptr_q);
          owner_d = sel;
          vld_d   = 1'b1;
          grnt_d  = ~(NUM_MASTERS'(1) << sel);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!bus.m_req_[owner_q]) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
          // The releasing owner's request is high, so it cannot win the handover.
          ptr_d = nxt_idx;
          if (any_req) begin
            sel     = rr_pick(bus.m_req_, nxt_idx);
            owner_d = sel;
            grnt_d  = ~(NUM_MASTERS'(1) << sel);
            cnt_d   = '0;
          end else begin
            vld_d   = 1'b0;
            grnt_d  = '1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Set takes priority over a simultaneous clear.
    if (WD_EN && state_q == GRANT && cnt_q == TO_LAST) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end
  end

  assign bus.m_grnt_     = grnt_q;
  assign bus.owner       = owner_q;
  assign bus.owner_vld   = vld_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, round-robin order, pointer wrap,
// single request, watchdog and set/clear collision, with TIMEOUT=4.
module tb_bus_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  bus_arbiter_if #(.NUM_MASTERS(4), .IDX_W(2)) bus ();

  bus_arbiter #(
    .NUM_MASTERS(4),
    .IDX_W      (2),
    .TIMEOUT    (4),
    .CNT_W      (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.m_req_  = 4'b1111;
    bus.err_clr = 1'b0;
    reset       = 1'b1;
    #1;
    n_tests++;
    if (bus.m_grnt_ !== 4'b1111 || bus.owner_vld !== 1'b0 || bus.owner !== 2'd0 ||
        bus.timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: grnt=%b vld=%b owner=%0d err=%b, want 1111 0 0 0",
               bus.m_grnt_, bus.owner_vld, bus.owner, bus.timeout_err);
    end
    #20 reset = 1'b0;
    tick();
    bus.m_req_ = 4'b1011;
    tick();
    n_tests++;
    if (bus.m_grnt_ !== 4'b1011 || bus.owner !== 2'd2 || bus.owner_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_grant: grnt=%b owner=%0d vld=%b, want 1011 2 1",
               bus.m_grnt_, bus.owner, bus.owner_vld);
    end
    repeat (5) tick();
    n_tests++;
    if (bus.timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_err: err=%b, want 1", bus.timeout_err);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (bus.m_grnt_ !== 4'b1111 || bus.owner_vld !== 1'b0 || bus.timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_grant: grnt=%b vld=%b err=%b, want 1111 0 0",
               bus.m_grnt_, bus.owner_vld, bus.timeout_err);
    end
    #1 reset = 1'b0;
    bus.m_req_ = 4'b1111;
    tick();
    bus.m_req_ = 4'b0111;
    tick();
    n_tests++;
    if (bus.m_grnt_ !== 4'b0111 || bus.owner !== 2'd3 || bus.owner_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_regrant: grnt=%b owner=%0d vld=%b, want 0111 3 1",
               bus.m_grnt_, bus.owner, bus.owner_vld);
    end
    bus.m_req_ = 4'b1111;
    tick();
    n_tests++;
    if (bus.m_grnt_ !== 4'b1111 || bus.owner_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: grnt=%b vld=%b, want 1111 0", bus.m_grnt_, bus.owner_vld);
    end
  endtask

  // Pointer is 0 here (master 3 just released), so all-request order is 0,1,2,3,0.
  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [3:0] rel;
    bus.m_req_ = 4'b0000;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b1111;
      exp_g[k % 4] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        n_tests++;
        if (bus.m_grnt_ !== exp_g || bus.owner !== 2'(k % 4) || bus.owner_vld !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_k%0d_c%0d: grnt=%b owner=%0d vld=%b, want %b %0d 1",
                   k, c, bus.m_grnt_, bus.owner, bus.owner_vld, exp_g, k % 4);
        end
        if (c < 2) tick();
      end
      if (k < 4) begin
        rel = 4'b0000;
        rel[k % 4] = 1'b1;
        bus.m_req_ = rel;
        tick();
        bus.m_req_ = 4'b0000;
      end else begin
        bus.m_req_ = 4'b1111;
        tick();
      end
    end
    n_tests++;
    if (bus.m_grnt_ !== 4'b1111 || bus.owner_vld !== 1'b0 || bus.owner !== 2'd0) begin
      n_fail++;
      $display("FAIL rr_idle: grnt=%b vld=%b owner=%0d, want 1111 0 0",
               bus.m_grnt_, bus.owner_vld, bus.owner);
    end
  endtask

  // Pointer is 1 on entry; master 3 wins alone, then 0 before 1 after the wrap.
  task automatic test_ptr_wrap();
    bus.m_req_ = 4'b0111;
    tick();
    n_tests++;
    if (bus.m_grnt_ !== 4'b0111 || bus.owner !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_own3: grnt=%b owner=%0d, want 0111 3", bus.m_grnt_, bus.owner);
    end
    bus.m_req_ = 4'b0100;
    tick();
    n_tests++;
    if (bus.m_grnt_ !== 4'b0111 || bus.owner !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_no_preempt: grnt=%b owner=%0d, want 0111 3", bus.m_grnt_, bus.owner);
    end
    bus.m_req_ = 4'b1100;
    tick();
    n_tests++;
    if (bus.m_grnt_ !== 4'b1110 || bus.owner !== 2'd0 || bus.owner_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_to0: grnt=%b owner=%0d vld=%b, want 1110 0 1",
               bus.m_grnt_, bus.owner, bus.owner_vld);
    end
    bus.m_req_ = 4'b1101;
    tick();
    n_tests++;
    if (bus.m_grnt_ !== 4'b1101 || bus.owner !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap_to1: grnt=%b owner=%0d, want 1101 1", bus.m_grnt_, bus.owner);
    end
    bus.m_req_ = 4'b1111;
    tick();
    n_tests++;
    if (bus.m_grnt_ !== 4'b1111 || bus.owner_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_idle: grnt=%b vld=%b, want 1111 0", bus.m_grnt_, bus.owner_vld);
    end
  endtask

  // Pointer is 2 on entry; master 0 alone is still found by the wrapped scan.
  task automatic test_single_request();
    bus.m_req_ = 4'b1110;
    tick();
    n_tests++;
    if (bus.m_grnt_ !== 4'b1110 || bus.owner !== 2'd0 || bus.owner_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: grnt=%b owner=%0d vld=%b, want 1110 0 1",
               bus.m_grnt_, bus.owner, bus.owner_vld);
    end
    repeat (4) tick();
    bus.m_req_ = 4'b1111;
    tick();
    n_tests++;
    if (bus.m_grnt_ !== 4'b1111 || bus.owner_vld !== 1'b0 || bus.owner !== 2'd0) begin
      n_fail++;
      $display("FAIL single_release: grnt=%b vld=%b owner=%0d, want 1111 0 0",
               bus.m_grnt_, bus.owner_vld, bus.owner);
    end
  endtask

  task automatic test_watchdog();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_tests++;
    if (bus.timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_preclear: err=%b, want 0", bus.timeout_err);
    end
    bus.m_req_ = 4'b1101;
    tick();
    for (int h = 1; h <= 10; h++) begin
      n_tests++;
      if (bus.m_grnt_ !== 4'b1101 || bus.timeout_err !== (h > 4)) begin
        n_fail++;
        $display("FAIL wd_held%0d: grnt=%b err=%b, want 1101 %b",
                 h, bus.m_grnt_, bus.timeout_err, (h > 4));
      end
      tick();
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_tests++;
    if (bus.timeout_err !== 1'b0 || bus.m_grnt_ !== 4'b1101) begin
      n_fail++;
      $display("FAIL wd_clear: err=%b grnt=%b, want 0 1101", bus.timeout_err, bus.m_grnt_);
    end
    bus.m_req_ = 4'b1111;
    tick();
  endtask

  task automatic test_set_clear_collision();
    bus.m_req_ = 4'b1011;
    tick();
    repeat (3) tick();
    n_tests++;
    if (bus.timeout_err !== 1'b0 || bus.m_grnt_ !== 4'b1011) begin
      n_fail++;
      $display("FAIL coll_before: err=%b grnt=%b, want 0 1011", bus.timeout_err, bus.m_grnt_);
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_tests++;
    if (bus.timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_set_wins: err=%b, want 1", bus.timeout_err);
    end
    bus.m_req_ = 4'b1111;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_round_robin();
    test_ptr_wrap();
    test_single_request();
    test_watchdog();
    test_set_clear_collision();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, want completion before 100000");
    $fatal(1, "timeout");
  end

endmodule
